// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size codes, FSM states and lane helpers for mem_access_unit
package mem_access_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Byte-enable pattern for an access of the given size, before lane shifting.
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // An access is misaligned when its byte offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] lane, input logic [1:0] size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return |lane[1:0];
            default: return |lane;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data_mem bus bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_misaligned;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_memread;
    logic              mem_memwrite;

    // Environment side: execute stage issuing requests plus the data_mem array.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
        input  mem_address, mem_data_in, mem_memread, mem_memwrite,
        output mem_data_out
    );

    // Unit side: accepts requests and drives data_mem.
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
        output mem_address, mem_data_in, mem_memread, mem_memwrite,
        input  mem_data_out
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational load extract/extend and store byte merge
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] rword,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_word
);
    logic [63:0] shifted;
    logic [63:0] wshift;
    logic [7:0]  bmask;

    // Shift the addressed lane down to bit 0 and sign/zero extend by size.
    always_comb begin
        shifted = rword >> {lane, 3'b000};
        case (size)
            SZ_B:    load_data = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
            SZ_H:    load_data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            SZ_W:    load_data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // Overlay the right-justified store bytes onto the read word at the lane.
    always_comb begin
        bmask      = lane_mask(size) << lane;
        wshift     = wdata << {lane, 3'b000};
        store_word = rword;
        for (int i = 0; i < 8; i++) begin
            if (bmask[i]) begin
                store_word[8*i +: 8] = wshift[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for data_mem with RMW for sub-doubleword stores
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              write_q, write_d;
    logic              mis_q, mis_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic              req_mis;

    assign req_mis = is_misaligned(bus.req_addr[2:0], bus.req_size);

    // word_q holds the store data until CAP, then the merged word for WR.
    mem_lane_align u_align (
        .lane        (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rword       (bus.mem_data_out),
        .wdata       (word_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: misaligned short-circuits, full-word stores skip the read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_mis)                                 state_d = ST_RESP;
                    else if (bus.req_write && bus.req_size == SZ_D) state_d = ST_WR;
                    else                                         state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = write_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches and captured/merged data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            mis_q   <= 1'b0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            write_q <= write_d;
            mis_q   <= mis_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
        end
    end

    // Latch the request on accept; in CAP either extract load data or merge the store.
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        write_d = write_q;
        mis_d   = mis_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        if (state_q == ST_IDLE && bus.req_valid) begin
            addr_d  = bus.req_addr;
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            write_d = bus.req_write;
            mis_d   = req_mis;
            word_d  = bus.req_wdata;
            rdata_d = '0;
        end else if (state_q == ST_CAP) begin
            if (write_q) word_d  = store_word;
            else         rdata_d = load_data;
        end
    end

    // Outputs decode directly from the state so strobes fall with reset.
    always_comb begin
        bus.req_ready      = (state_q == ST_IDLE);
        bus.mem_memread    = (state_q == ST_RD);
        bus.mem_memwrite   = (state_q == ST_WR);
        bus.mem_address    = {addr_q[ADDR_W-1:3], 3'b000};
        bus.mem_data_in    = (state_q == ST_WR) ? word_q : '0;
        bus.rsp_valid      = (state_q == ST_RESP);
        bus.rsp_misaligned = (state_q == ST_RESP) && mis_q;
        bus.rsp_rdata      = (state_q == ST_RESP) ? rdata_q : '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit paired with a data_mem model
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [63:0] mem     [16] = '{default: 64'h0};
    logic [63:0] ref_mem [16] = '{default: 64'h0};
    int n_pass  = 0;
    int n_total = 0;

    // data_mem: sample at rising edge, read data appears after that edge
    always @(posedge clk) begin
        if (bus.mem_memwrite) mem[bus.mem_address[6:3]] <= bus.mem_data_in;
        if (bus.mem_memread)  bus.mem_data_out <= mem[bus.mem_address[6:3]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // bus invariants every cycle
    always @(negedge clk) begin
        chk("no_rd_wr_overlap", 64'(bus.mem_memread && bus.mem_memwrite), 64'd0);
        chk("addr_dword_aligned", 64'(bus.mem_address[2:0]), 64'd0);
    end

    function automatic logic [63:0] model_load(input logic [63:0] w, input int lane,
                                               input int nb, input bit uns);
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(lane+i) +: 8];
        if (!uns && v[8*nb-1])
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hff;
        return v;
    endfunction

    function automatic logic [63:0] model_store(input logic [63:0] w, input int lane,
                                                input int nb, input logic [63:0] wd);
        logic [63:0] v;
        v = w;
        for (int i = 0; i < nb; i++) v[8*(lane+i) +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    task automatic drive_junk();
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = 64'($urandom_range(0, 127));
        bus.req_wdata    = {$urandom, $urandom};
    endtask

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input bit has_lit, input logic [63:0] lit);
        int nb, lane, idx, lat, cyc, rd_cnt, wr_cnt;
        bit mis, got;
        logic [63:0] exp_rd, got_rd;
        logic got_mis;
        nb   = 1 << sz;
        lane = int'(addr[2:0]);
        idx  = int'(addr[6:3]);
        mis  = (lane % nb) != 0;
        exp_rd = 64'h0;
        if (mis)            lat = 1;
        else if (!wr)       begin lat = 3; exp_rd = model_load(ref_mem[idx], lane, nb, uns); end
        else if (sz == SZ_D) lat = 2;
        else                lat = 4;

        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        cyc = 0; got = 0; rd_cnt = 0; wr_cnt = 0;
        got_rd = 64'h0; got_mis = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            rd_cnt += int'(bus.mem_memread);
            wr_cnt += int'(bus.mem_memwrite);
            if (bus.rsp_valid) begin
                got     = 1;
                got_rd  = bus.rsp_rdata;
                got_mis = bus.rsp_misaligned;
                bus.req_valid = 1'b0;
            end else begin
                drive_junk();
            end
        end
        if (!got) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            bus.req_valid = 1'b0;
        end else begin
            chk("rsp_latency", 64'(cyc), 64'(lat));
            chk("rsp_rdata", got_rd, exp_rd);
            chk("rsp_misaligned", 64'(got_mis), 64'(mis));
            chk("memread_count", 64'(rd_cnt), 64'((!mis && !(wr && sz == SZ_D)) ? 1 : 0));
            chk("memwrite_count", 64'(wr_cnt), 64'((!mis && wr) ? 1 : 0));
            if (has_lit) chk("literal_rdata", got_rd, lit);
        end
        if (wr && !mis) ref_mem[idx] = model_store(ref_mem[idx], lane, nb, wdata);
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    task automatic reset_mid(input bit wr, input logic [1:0] sz, input logic [63:0] addr,
                             input logic [63:0] wdata, input int abort_cyc);
        int idx;
        idx = int'(addr[6:3]);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        for (int k = 1; k <= abort_cyc; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        if (abort_cyc == 1) chk("memread_before_reset", 64'(bus.mem_memread), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_memread", 64'(bus.mem_memread), 64'd0);
        chk("rst_memwrite", 64'(bus.mem_memwrite), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_mem_data_in", bus.mem_data_in, 64'd0);
        chk("rst_mem_address", bus.mem_address, 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("no_rsp_in_reset", 64'(bus.rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        chk("ready_after_reset", 64'(bus.req_ready), 64'd1);
        chk("mem_unchanged_after_abort", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = SZ_B;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 64'h0;
        bus.req_wdata    = 64'h0;
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_mis", 64'(bus.rsp_misaligned), 64'd0);
        chk("reset_memread", 64'(bus.mem_memread), 64'd0);
        chk("reset_memwrite", 64'(bus.mem_memwrite), 64'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("reset_mem_address", bus.mem_address, 64'd0);
        chk("reset_mem_data_in", bus.mem_data_in, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed sequence with hand-computed results
        do_req(1, SZ_D, 0, 64'h40, 64'h1234567890abcdef, 1, 64'h0);
        do_req(0, SZ_D, 0, 64'h40, 64'h0, 1, 64'h1234567890abcdef);
        do_req(1, SZ_B, 0, 64'h43, 64'h80, 1, 64'h0);
        do_req(0, SZ_D, 0, 64'h40, 64'h0, 1, 64'h1234567880abcdef);
        do_req(0, SZ_B, 0, 64'h43, 64'h0, 1, 64'hffffffffffffff80);
        do_req(0, SZ_B, 1, 64'h43, 64'h0, 1, 64'h80);
        do_req(0, SZ_H, 0, 64'h41, 64'h0, 1, 64'h0);
        do_req(1, SZ_W, 0, 64'h42, 64'hcafef00d, 1, 64'h0);
        do_req(0, SZ_D, 0, 64'h40, 64'h0, 1, 64'h1234567880abcdef);
        do_req(1, SZ_W, 0, 64'h44, 64'hdeadbeef, 1, 64'h0);
        do_req(0, SZ_D, 0, 64'h40, 64'h0, 1, 64'hdeadbeef80abcdef);
        do_req(0, SZ_W, 0, 64'h44, 64'h0, 1, 64'hffffffffdeadbeef);
        do_req(0, SZ_W, 1, 64'h44, 64'h0, 1, 64'h00000000deadbeef);

        // abort a byte store in CAP and a load in RD
        reset_mid(1, SZ_B, 64'h45, 64'h5a, 2);
        do_req(0, SZ_D, 0, 64'h40, 64'h0, 1, 64'hdeadbeef80abcdef);
        reset_mid(0, SZ_D, 64'h48, 64'h0, 1);

        // fill remaining memory, then random traffic
        for (int i = 0; i < 16; i++)
            if (i != 8) do_req(1, SZ_D, 0, 64'(i * 8), {$urandom, $urandom}, 0, 64'h0);
        for (int n = 0; n < 120; n++) begin
            logic [1:0]  sz;
            logic [63:0] a;
            sz = 2'($urandom);
            a  = 64'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << sz) - 64'd1);
            do_req(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, 0, 64'h0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
